// File: rtl/lm70_read_ctrl.sv
// LM70 SPI temperature read controller: manual/periodic 16-bit frame reads with a frame check.
// Optional threshold alarm with hysteresis when LM70_ALARM_EN is defined.
module lm70_read_ctrl #(
    parameter int unsigned HALF_DIV = 1,
    parameter int unsigned PERIOD   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               auto_en,
    input  logic               sio,
`ifdef LM70_ALARM_EN
    input  logic signed [10:0] alarm_hi,
    input  logic        [3:0]  alarm_hyst,
    output logic               alarm,
`endif
    output logic               cs_n,
    output logic               sck,
    output logic               busy,
    output logic               valid,
    output logic        [10:0] temp_code,
    output logic               frame_err
);

    localparam int unsigned CW = 8;
    localparam int unsigned TW = 20;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_cnt;
    logic [15:0]     shift_reg;
    logic [TW-1:0]   timer;
    logic            expire;
    logic            accept;
    logic            half_end;

    assign expire   = auto_en && (timer == TW'(PERIOD - 1));
    assign accept   = (state == IDLE) && (start || expire);
    assign half_end = (cnt == CW'(HALF_DIV - 1));

`ifdef LM70_ALARM_EN
    logic signed [10:0] new_code;
    logic signed [11:0] low_thr;
    assign new_code = shift_reg[15:5];
    assign low_thr  = $signed({alarm_hi[10], alarm_hi}) - $signed({8'd0, alarm_hyst});
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            timer     <= '0;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            temp_code <= '0;
            frame_err <= 1'b0;
`ifdef LM70_ALARM_EN
            alarm     <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;

            // Period timer restarts from every accepted read; it holds at expiry until accepted.
            if (!auto_en || accept) begin
                timer <= '0;
            end else if (!expire) begin
                timer <= timer + TW'(1);
            end

            case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sck  <= 1'b0;
                    busy <= accept;
                    if (accept) begin
                        state <= SETUP;
                        cs_n  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        state   <= SHIFT;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (!sck) begin
                            // Capture on the edge that raises sck.
                            sck       <= 1'b1;
                            shift_reg <= {shift_reg[14:0], sio};
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        cnt   <= '0;
                        cs_n  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    temp_code <= shift_reg[15:5];
                    frame_err <= (shift_reg[4:2] != 3'b111);
                    valid     <= 1'b1;
                    state     <= IDLE;
`ifdef LM70_ALARM_EN
                    if (new_code > alarm_hi) begin
                        alarm <= 1'b1;
                    end else if ($signed({new_code[10], new_code}) < low_thr) begin
                        alarm <= 1'b0;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    cs_n  <= 1'b1;
                    sck   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm70_read_ctrl.sv
// Scoreboard bench for lm70_read_ctrl: LM70 sensor model, random frames, periodic mode, mid-read reset.
module tb_lm70_read_ctrl;

    localparam int unsigned HD  = 1;
    localparam int unsigned PER = 100;

    logic clk = 1'b0;
    logic rst, start, auto_en, sio;
    logic cs_n, sck, busy, valid, frame_err;
    logic [10:0] temp_code;
`ifdef LM70_ALARM_EN
    logic signed [10:0] alarm_hi;
    logic [3:0] alarm_hyst;
    logic alarm;
`endif

    lm70_read_ctrl #(.HALF_DIV(HD), .PERIOD(PER)) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .sio(sio),
`ifdef LM70_ALARM_EN
        .alarm_hi(alarm_hi), .alarm_hyst(alarm_hyst), .alarm(alarm),
`endif
        .cs_n(cs_n), .sck(sck), .busy(busy), .valid(valid),
        .temp_code(temp_code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] code;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          vtimes[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          nvalid = 0;
    int          cyc = 0;
    logic [15:0] cur_frame = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Sensor model: presents frame MSB first, advances on each sck falling edge.
    int   sidx = 0;
    logic s_prev_sck = 1'b0;
    always @(negedge clk) begin
        if (cs_n) sidx = 0;
        else if (s_prev_sck && !sck && sidx < 16) sidx++;
        s_prev_sck = sck;
        sio = (sidx < 16) ? cur_frame[15 - sidx] : 1'b0;
    end

    // Monitor: pops expectations on valid, checks latency, sck edges and output hold.
    int          acc_cyc = 0;
    int          rises = 0;
    logic        bad_inv = 1'b0;
    logic        m_prev_busy = 1'b0;
    logic        m_prev_sck = 1'b0;
    logic [10:0] hold_code = '0;
    logic        hold_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            rises = 0; bad_inv = 1'b0; hold_code = '0; hold_err = 1'b0;
        end else begin
            if (!m_prev_busy && busy) acc_cyc = cyc;
            if (!cs_n && sck && !m_prev_sck) rises++;
            if (cs_n && sck) bad_inv = 1'b1;
            if (valid) begin
                nvalid++;
                vtimes.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_valid: got valid=1 expected none at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("temp_code", 32'(temp_code), 32'(e.code));
                    chk("frame_err", 32'(frame_err), 32'(e.err));
                    chk("latency", 32'(cyc - acc_cyc), 32'(34 * HD + 1));
                    chk("sck_rises", 32'(rises), 32'd16);
                    chk("sck_while_cs_high", 32'(bad_inv), 32'd0);
                    hold_code = e.code; hold_err = e.err;
                end
                rises = 0; bad_inv = 1'b0;
            end else begin
                chk("hold", {20'd0, temp_code, frame_err}, {20'd0, hold_code, hold_err});
            end
        end
        m_prev_busy = busy;
        m_prev_sck  = sck;
    end

    // Frame built from a temperature code; [4:2] = 3'b111 unless a bad pattern is given.
    function automatic logic [15:0] make_frame(input int t, input int bad, input int lo);
        int tb3;
        tb3 = (bad >= 0) ? bad : 7;
        return 16'(((t & 'h7FF) << 5) | (tb3 << 2) | (lo & 3));
    endfunction

    task automatic push_exp(input int t, input int bad);
        exp_t e;
        e.code = 11'(t & 'h7FF);
        e.err  = (bad >= 0) && (bad != 7);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin @(posedge clk); #1; n++; end
        if (busy) begin n_cmp++; n_fail++; $display("FAIL idle_timeout: got busy=1 expected 0"); end
    endtask

    task automatic wait_valid(input int budget);
        int n0 = nvalid;
        int n = 0;
        while (nvalid == n0 && n < budget) begin @(posedge clk); #1; n++; end
        if (nvalid == n0) begin n_cmp++; n_fail++; $display("FAIL valid_timeout: got no valid expected one within %0d", budget); end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_read(input int t, input int bad, input int lo);
        wait_idle(200);
        cur_frame = make_frame(t, bad, lo);
        push_exp(t, bad);
        pulse_start();
        wait_valid(200);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; auto_en = 1'b0; sio = 1'b0;
`ifdef LM70_ALARM_EN
        alarm_hi = 11'sd100; alarm_hyst = 4'd8;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_temp", 32'(temp_code), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // -25 C: frame F39F, then +25 C.
        wait_idle(10);
        cur_frame = 16'hF39F;
        push_exp(-100, -1);
        pulse_start();
        wait_valid(200);
        do_read(100, -1, 0);
        // Bad check bits then good frame clears the error.
        do_read(-7, 5, 2);
        do_read(63, -1, 1);
        // Boundary codes and random frames.
        do_read(1023, -1, 3);
        do_read(-1024, -1, 0);
        for (int i = 0; i < 16; i++) begin
            int t, bad;
            t   = int'($urandom_range(0, 2047)) - 1024;
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            do_read(t, bad, int'($urandom_range(0, 3)));
        end

        // Periodic reads; a start during a read must be ignored.
        wait_idle(10);
        cur_frame = make_frame(-300, -1, 0);
        vtimes.delete();
        auto_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            push_exp(-300, -1);
            while (!busy && n < 300) begin @(posedge clk); #1; n++; end
            if (i == 1) begin
                repeat (5) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            wait_valid(100);
        end
        auto_en = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        if (vtimes.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("period", 32'(vtimes[i] - vtimes[i-1]), 32'(PER));
        end else begin
            chk("period_count", 32'(vtimes.size()), 32'd4);
        end

`ifdef LM70_ALARM_EN
        do_read(104, -1, 0);
        chk("alarm_26C", 32'(alarm), 32'd1);
        do_read(96, -1, 0);
        chk("alarm_24C", 32'(alarm), 32'd1);
        do_read(88, -1, 0);
        chk("alarm_22C", 32'(alarm), 32'd0);
`endif

        // Reset at cycle 10 of SHIFT aborts the read without a valid.
        wait_idle(10);
        cur_frame = make_frame(77, -1, 0);
        pulse_start();
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sck", 32'(sck), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_temp", 32'(temp_code), 32'd0);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_valid_busy", 32'(busy), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lm70_read_ctrl.md
LM70_READ_CTRL -- requirements
Module: lm70_read_ctrl

Interface
REQ-001 Parameter HALF_DIV, default 1: number of clk cycles per SCK half-period; legal range 1..255.
REQ-002 Parameter PERIOD, default 1000: clk cycles between automatic reads; legal range is at least 64*HALF_DIV, up to 2^20-1.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle read request; sampled only in IDLE.
REQ-006 auto_en  in  1  1 = periodic reads every PERIOD cycles.
REQ-007 sio  in  1  serial data from the LM70 (SIO).
REQ-008 cs_n  out  1  LM70 chip select, active low.
REQ-009 sck  out  1  LM70 serial clock; idles low.
REQ-010 busy  out  1  high from start accept until the cycle after valid.
REQ-011 valid  out  1  one-cycle pulse when temp_code/frame_err update.
REQ-012 temp_code  out  11  signed LM70 code (0.25 C/LSB), frame bits [15:5].
REQ-013 frame_err  out  1  high when the last frame's bits [4:2] were not 3'b111.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, DONE; all outputs are registered.
REQ-015 IDLE: cs_n=1 and sck=0; go to SETUP on start=1, or on timer expiry when auto_en=1.
REQ-016 SETUP: cs_n=0 and sck=0 for HALF_DIV cycles, then go to SHIFT.
REQ-017 SHIFT: 16 bit-slots, each made of HALF_DIV cycles with sck=0 followed by HALF_DIV cycles with sck=1.
REQ-018 sio SHALL be sampled on the clk edge where sck rises, and shifted MSB-first into a 16-bit register.
REQ-019 HOLD: sck=0 and cs_n=0 for HALF_DIV cycles, then cs_n=1 and go to DONE; sck SHALL never be high while cs_n=1.
REQ-020 DONE lasts one cycle: temp_code<=shift[15:5], frame_err<=(shift[4:2]!=3'b111), valid=1, then go to IDLE.
REQ-021 Latency: valid SHALL assert exactly 34*HALF_DIV+1 cycles after the accepting edge (35 cycles for HALF_DIV=1).
REQ-022 start or timer expiry while not in IDLE SHALL be ignored; no queuing.
REQ-023 start and timer expiry in the same cycle SHALL produce exactly one read.
REQ-024 Period timer: counts only while auto_en=1; reloads on every accepted read; expiry is at PERIOD cycles after the last accept.
REQ-025 Period timer: clearing auto_en resets the count and does not abort a read in progress.
REQ-026 temp_code and frame_err SHALL hold their values between valid pulses.

Reset
REQ-027 rst=1 SHALL force next cycle: state=IDLE, cs_n=1, sck=0, busy=0, valid=0, temp_code=0, frame_err=0, timer=0, shift=0.
REQ-028 Reset mid-transaction SHALL abort the read with no valid pulse; cs_n rises and sck falls on the same edge.

Configuration
REQ-029 Macro LM70_ALARM_EN SHALL add: input alarm_hi[10:0] (signed threshold), input alarm_hyst[3:0], and output alarm (reset 0).
REQ-030 With LM70_ALARM_EN: at each valid, alarm sets when temp_code>alarm_hi, clears when temp_code<alarm_hi-alarm_hyst, otherwise holds; all compares are signed.
REQ-031 Without LM70_ALARM_EN: none of the REQ-029 ports or logic exist; all other behaviour is identical.

Verification
REQ-032 HALF_DIV=1, sensor model at -25 C (frame 16'hF39F), start pulse -> valid at +35 cycles, temp_code=11'h79C (-100), frame_err=0.
REQ-033 Sensor at +25 C -> temp_code=11'h064; sck shows exactly 16 rising edges while cs_n=0; sck=0 whenever cs_n=1.
REQ-034 Frame with bits [4:2]=3'b101 -> valid with frame_err=1; the next good frame clears it.
REQ-035 auto_en=1, PERIOD=100 -> valid pulses exactly 100 cycles apart; a start pulse issued while busy causes no extra read.
REQ-036 rst asserted at cycle 10 of SHIFT -> next cycle cs_n=1, sck=0, busy=0; no valid pulse; temp_code=0.
REQ-037 LM70_ALARM_EN, alarm_hi=+100 (25 C), alarm_hyst=8 -> alarm=1 at 26 C, stays 1 at 24 C, 0 at 22 C.
